// File: rtl/move_arbiter_if.sv
// Move-command handshake between the arbiter (master) and the board-update logic (slave).
// The master holds move_valid/move_dir until the slave accepts with move_ready.
interface move_arbiter_if;
  logic       move_valid;
  logic       move_ready;
  logic [1:0] move_dir;

  modport master (output move_valid, output move_dir, input move_ready);
  modport slave  (input move_valid, input move_dir, output move_ready);
endinterface

// File: rtl/move_arbiter.sv
// Latches button pulses and issues one round-robin move per handshake, then idles COOLDOWN cycles.
// A move appears one cycle after its pulse and is held stable until move_ready; presses keep latching meanwhile.
module move_arbiter #(
  parameter int COOLDOWN = 1024,
  parameter int CW       = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  move_arbiter_if.master mv,
  output logic           busy,
  output logic [3:0]     pending
);

  typedef enum logic [1:0] {IDLE, ISSUE, COOL} state_t;

  state_t        state, state_n;
  logic [3:0]    pend, pend_n;
  logic [3:0]    req, cand;
  logic [1:0]    ptr, ptr_n;
  logic [1:0]    dir, dir_n;
  logic [1:0]    grant, idx;
  logic          valid, valid_n;
  logic          found;
  logic [CW-1:0] cnt, cnt_n;

  assign req  = en ? {btn_right, btn_left, btn_down, btn_up} : 4'b0000;
  assign cand = pend | req;

  // Scan from ptr upward (mod 4); the first set candidate wins.
  always_comb begin
    found = 1'b0;
    grant = ptr;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    pend_n  = pend | req;
    ptr_n   = ptr;
    dir_n   = dir;
    valid_n = valid;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          // A same-cycle pulse on the winner is consumed by this grant.
          pend_n  = cand & ~(4'b0001 << grant);
          ptr_n   = grant + 2'd1;
          dir_n   = grant;
          valid_n = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (mv.move_ready) begin
          valid_n = 1'b0;
          cnt_n   = CW'(COOLDOWN);
          state_n = (COOLDOWN == 0) ? IDLE : COOL;
        end
      end
      COOL: begin
        if (cnt != '0) cnt_n = cnt - CW'(1);
        if (cnt <= CW'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= 4'b0000;
      ptr   <= 2'd0;
      dir   <= 2'd0;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      ptr   <= ptr_n;
      dir   <= dir_n;
      valid <= valid_n;
      cnt   <= cnt_n;
    end
  end

  assign mv.move_valid = valid;
  assign mv.move_dir   = dir;
  assign busy          = (state != IDLE);
  assign pending       = pend;

endmodule

// File: tb/tb_move_arbiter.sv
// Directed bench for move_arbiter: COOLDOWN=4 main instance plus a COOLDOWN=0 instance on shared inputs.
module tb_move_arbiter;

  logic       clk = 1'b0;
  logic       rst, en, btn_up, btn_down, btn_left, btn_right;
  logic       busy, busy0;
  logic [3:0] pending, pending0;

  always #5 clk = ~clk;

  move_arbiter_if mif();
  move_arbiter_if mif0();

  move_arbiter #(.COOLDOWN(4)) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .mv(mif.master), .busy(busy), .pending(pending)
  );

  move_arbiter #(.COOLDOWN(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .mv(mif0.master), .busy(busy0), .pending(pending0)
  );

  int checks   = 0;
  int failures = 0;

  // Moves observed by collect(): step index, direction, pending at that cycle.
  int         got_n;
  int         got_t   [8];
  logic [1:0] got_dir [8];
  logic [3:0] got_pend[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_btns();
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_btns();
    step();
    rst = 1'b0;
  endtask

  // Bounded observation window of the main instance; assumes move_ready=1 so each valid cycle is one move.
  task automatic collect(input int ncyc);
    got_n = 0;
    for (int t = 1; t <= ncyc; t++) begin
      step();
      if (mif.move_valid === 1'b1 && got_n < 8) begin
        got_t[got_n]    = t;
        got_dir[got_n]  = mif.move_dir;
        got_pend[got_n] = pending;
        got_n++;
      end
    end
  endtask

  task automatic test_reset();
    en = 1'b1; mif.move_ready = 1'b1; mif0.move_ready = 1'b1;
    do_reset();
    checks++; if (mif.move_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", mif.move_valid); end
    checks++; if (mif.move_dir !== 2'd0) begin failures++; $display("FAIL reset_dir got=%0d exp=0", mif.move_dir); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    checks++; if (mif0.move_valid !== 1'b0) begin failures++; $display("FAIL reset_valid0 got=%b exp=0", mif0.move_valid); end
  endtask

  task automatic test_single_left();
    int nb, nv, bad;
    do_reset();
    mif.move_ready = 1'b1;
    btn_left = 1'b1;
    step();
    clear_btns();
    checks++; if (mif.move_valid !== 1'b1) begin failures++; $display("FAIL left_valid got=%b exp=1", mif.move_valid); end
    checks++; if (mif.move_dir !== 2'd2) begin failures++; $display("FAIL left_dir got=%0d exp=2", mif.move_dir); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL left_busy got=%b exp=1", busy); end
    checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL left_pending got=%b exp=0000", pending); end
    nb = 1; nv = 1; bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (busy === 1'b1) nb++;
      if (mif.move_valid === 1'b1) nv++;
      if (pending !== 4'b0000) bad++;
    end
    checks++; if (nb !== 5) begin failures++; $display("FAIL left_busy_cycles got=%0d exp=5", nb); end
    checks++; if (nv !== 1) begin failures++; $display("FAIL left_valid_cycles got=%0d exp=1", nv); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL left_pending_nonzero got=%0d exp=0", bad); end
  endtask

  task automatic test_all_four();
    logic [3:0] exp_pend[3];
    exp_pend[0] = 4'b1100; exp_pend[1] = 4'b1000; exp_pend[2] = 4'b0000;
    do_reset();
    mif.move_ready = 1'b1;
    btn_up = 1'b1; btn_down = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
    step();
    clear_btns();
    checks++; if (mif.move_valid !== 1'b1 || mif.move_dir !== 2'd0) begin failures++; $display("FAIL all4_first got=%b/%0d exp=1/0", mif.move_valid, mif.move_dir); end
    checks++; if (pending !== 4'b1110) begin failures++; $display("FAIL all4_pend0 got=%b exp=1110", pending); end
    collect(25);
    checks++; if (got_n !== 3) begin failures++; $display("FAIL all4_count got=%0d exp=3", got_n); end
    for (int k = 0; k < 3 && k < got_n; k++) begin
      checks++; if (got_dir[k] !== 2'(k + 1)) begin failures++; $display("FAIL all4_dir%0d got=%0d exp=%0d", k, got_dir[k], k + 1); end
      checks++; if (got_t[k] !== 6 * (k + 1)) begin failures++; $display("FAIL all4_time%0d got=%0d exp=%0d", k, got_t[k], 6 * (k + 1)); end
      checks++; if (got_pend[k] !== exp_pend[k]) begin failures++; $display("FAIL all4_pend%0d got=%b exp=%b", k, got_pend[k], exp_pend[k]); end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    mif.move_ready = 1'b0;
    btn_up = 1'b1;
    step();
    clear_btns();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (mif.move_valid !== 1'b1 || mif.move_dir !== 2'd0) bad++;
      if (i == 2 || i == 6) btn_down = 1'b1;
      if (i == 4) btn_up = 1'b1;
      step();
      clear_btns();
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad); end
    checks++; if (mif.move_valid !== 1'b1 || mif.move_dir !== 2'd0) begin failures++; $display("FAIL bp_still_valid got=%b/%0d exp=1/0", mif.move_valid, mif.move_dir); end
    checks++; if (pending !== 4'b0011) begin failures++; $display("FAIL bp_pending got=%b exp=0011", pending); end
    mif.move_ready = 1'b1;
    collect(30);
    checks++; if (got_n !== 2) begin failures++; $display("FAIL bp_count got=%0d exp=2", got_n); end
    checks++; if (got_n >= 1 && (got_dir[0] !== 2'd1 || got_t[0] !== 6)) begin failures++; $display("FAIL bp_move0 got=%0d@%0d exp=1@6", got_dir[0], got_t[0]); end
    checks++; if (got_n >= 2 && (got_dir[1] !== 2'd0 || got_t[1] !== 12)) begin failures++; $display("FAIL bp_move1 got=%0d@%0d exp=0@12", got_dir[1], got_t[1]); end
  endtask

  task automatic test_fairness();
    do_reset();
    mif.move_ready = 1'b1;
    btn_right = 1'b1;
    step();
    clear_btns();
    checks++; if (mif.move_dir !== 2'd3) begin failures++; $display("FAIL rr_first got=%0d exp=3", mif.move_dir); end
    collect(6);
    checks++; if (got_n !== 0) begin failures++; $display("FAIL rr_quiet got=%0d exp=0", got_n); end
    btn_up = 1'b1; btn_right = 1'b1;
    step();
    clear_btns();
    checks++; if (mif.move_valid !== 1'b1 || mif.move_dir !== 2'd0) begin failures++; $display("FAIL rr_up_first got=%b/%0d exp=1/0", mif.move_valid, mif.move_dir); end
    collect(12);
    checks++; if (got_n !== 1 || got_dir[0] !== 2'd3) begin failures++; $display("FAIL rr_right_next got=%0d moves dir=%0d exp=1 dir=3", got_n, got_dir[0]); end
  endtask

  task automatic test_enable();
    do_reset();
    mif.move_ready = 1'b1;
    en = 1'b0;
    btn_up = 1'b1;
    step();
    clear_btns();
    checks++; if (mif.move_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL en_block got=%b/%b exp=0/0", mif.move_valid, busy); end
    checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL en_pending got=%b exp=0000", pending); end
    en = 1'b1; mif.move_ready = 1'b0;
    btn_up = 1'b1; btn_left = 1'b1;
    step();
    clear_btns();
    checks++; if (mif.move_valid !== 1'b1 || mif.move_dir !== 2'd0 || pending !== 4'b0100) begin failures++; $display("FAIL en_issue got=%b/%0d/%b exp=1/0/0100", mif.move_valid, mif.move_dir, pending); end
    en = 1'b0;
    btn_down = 1'b1;
    step();
    clear_btns();
    checks++; if (mif.move_valid !== 1'b1 || pending !== 4'b0100) begin failures++; $display("FAIL en_drop_hold got=%b/%b exp=1/0100", mif.move_valid, pending); end
    mif.move_ready = 1'b1;
    collect(20);
    checks++; if (got_n !== 1 || got_dir[0] !== 2'd2) begin failures++; $display("FAIL en_serve got=%0d moves dir=%0d exp=1 dir=2", got_n, got_dir[0]); end
    checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL en_final_pending got=%b exp=0000", pending); end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    mif.move_ready = 1'b0;
    btn_up = 1'b1; btn_down = 1'b1; btn_left = 1'b1;
    step();
    clear_btns();
    checks++; if (mif.move_valid !== 1'b1 || pending !== 4'b0110) begin failures++; $display("FAIL rmi_setup got=%b/%b exp=1/0110", mif.move_valid, pending); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (mif.move_valid !== 1'b0 || pending !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL rmi_cleared got=%b/%b/%b exp=0/0000/0", mif.move_valid, pending, busy); end
    mif.move_ready = 1'b1;
    btn_up = 1'b1; btn_right = 1'b1;
    step();
    clear_btns();
    checks++; if (mif.move_valid !== 1'b1 || mif.move_dir !== 2'd0) begin failures++; $display("FAIL rmi_ptr0 got=%b/%0d exp=1/0", mif.move_valid, mif.move_dir); end
    collect(12);
  endtask

  task automatic test_cooldown_zero();
    do_reset();
    mif.move_ready = 1'b1; mif0.move_ready = 1'b1;
    btn_up = 1'b1; btn_down = 1'b1;
    step();
    clear_btns();
    checks++; if (mif0.move_valid !== 1'b1 || mif0.move_dir !== 2'd0) begin failures++; $display("FAIL cd0_first got=%b/%0d exp=1/0", mif0.move_valid, mif0.move_dir); end
    step();
    checks++; if (mif0.move_valid !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL cd0_gap got=%b/%b exp=0/0", mif0.move_valid, busy0); end
    step();
    checks++; if (mif0.move_valid !== 1'b1 || mif0.move_dir !== 2'd1) begin failures++; $display("FAIL cd0_second got=%b/%0d exp=1/1", mif0.move_valid, mif0.move_dir); end
    step();
    checks++; if (mif0.move_valid !== 1'b0 || pending0 !== 4'b0000) begin failures++; $display("FAIL cd0_done got=%b/%b exp=0/0000", mif0.move_valid, pending0); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    mif.move_ready = 1'b1; mif0.move_ready = 1'b1;
    test_reset();
    test_single_left();
    test_all_four();
    test_backpressure();
    test_fairness();
    test_enable();
    test_reset_mid_issue();
    test_cooldown_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_arbiter.md
# move_arbiter

Sequences the four debounced direction buttons into single move commands for the board-update logic. Each debouncer emits a one-cycle pulse per press; this block latches those pulses, picks one direction round-robin when several are pending, and presents it on a valid/ready handshake. After each accepted move it enforces a cooldown so that at most one move is issued per window.

## Interface

Parameters:
- `COOLDOWN`, default 1024: idle cycles enforced after each accepted move; 0 disables the cooldown.
- `CW`, default `$clog2(COOLDOWN+1)` (minimum 1): cooldown counter width.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  when low, incoming pulses are ignored (not latched).
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  one-cycle press pulses from debouncers.
- `move_ready`  in  1  board logic accepts the move on a cycle where `move_valid` is also high.
- `move_valid`  out  1  move command valid.
- `move_dir`  out  2  0=up, 1=down, 2=left, 3=right.
- `busy`  out  1  high in any state other than IDLE.
- `pending`  out  4  latched unserved presses; bit index = direction code.

## Operation

- Requests: `req[3:0] = en ? {right,left,down,up} : 0`. Pending register `pend[3:0]` accumulates requests.
- Round-robin pointer `ptr[1:0]`: the highest-priority direction is `ptr`, then `ptr+1`, and so on, modulo 4. After a grant of direction d, `ptr <= d+1` mod 4.
- States:
  - **IDLE**: candidates are `pend | req`. If any candidate exists, grant the winner g. Load `move_dir <= g` and `move_valid <= 1`, then go to ISSUE. Clear `pend[g]`; a same-cycle pulse on g is consumed by the grant. Set all other candidate bits in `pend`.
  - **ISSUE**: hold `move_valid` and `move_dir` stable. On `move_ready`=1, drop `move_valid` and load the counter with `COOLDOWN`. Go to COOLDOWN, or go directly to IDLE if `COOLDOWN`=0. Requests OR into `pend`.
  - **COOLDOWN**: the counter decrements every cycle. When it is 1 and decrementing, go to IDLE, so the state lasts exactly `COOLDOWN` cycles. Requests OR into `pend`.
- A direction already pending absorbs repeat pulses; there is no count or queue depth beyond 1 per direction.
- `en` low does not abort an in-flight handshake and does not clear `pend`. It only blocks new latching and new pulses. Pending presses are still served.
- `pending` output = `pend` register. `busy` = (state != IDLE).

## Timing

- Reset values: state IDLE, `pend`=0, `ptr`=0, counter=0, `move_valid`=0, `move_dir`=0, `busy`=0.
- Reset mid-handshake drops `move_valid` on the next edge and discards all pending presses.
- Latency: a pulse in IDLE at cycle N produces `move_valid`=1 at cycle N+1.
- With `move_ready` tied high:
  - Accept occurs at N+1.
  - COOLDOWN occupies cycles N+2 through N+1+`COOLDOWN`.
  - The next grant decision is made at N+2+`COOLDOWN`, so the next `move_valid` appears at N+3+`COOLDOWN`.
  - Back-to-back spacing is therefore `COOLDOWN`+2 cycles.
- With `COOLDOWN`=0, the state returns to IDLE at N+2 and the next `move_valid` appears at N+3 (minimum spacing 2 cycles).
- `move_valid` never deasserts without an accept, and `move_dir` never changes while `move_valid`=1.
- Simultaneous pulses in IDLE: one is granted and the rest are latched in the same edge; none is lost.

## Test plan

- Reset, then pulse `btn_left` one cycle with `move_ready`=1 → `move_valid`=1 and `move_dir`=2 for exactly one cycle, on the cycle after the pulse. `busy` then stays high for 1+`COOLDOWN` cycles and `pending`=0 throughout.
- `COOLDOWN`=4; all four buttons pulse in the same cycle; `move_ready`=1 → moves issued in order 0,1,2,3, each spaced 6 cycles apart. `pending` goes 1110 → 1100 → 1000 → 0000.
- Hold `move_ready`=0 for 10 cycles after `btn_up`; pulse `btn_down` twice and `btn_up` once during the wait → `move_dir` holds 0 and `move_valid` stays high. After ready, and after cooldown, exactly two more moves issue (1 then 0, ptr=1 first), then nothing further.
- Round-robin fairness: grant 3 (right) so ptr=0, then pulse up and right together → up (0) is granted first, then right.
- `en`=0 during a pulse in IDLE → no `move_valid` and `pending`=0. Dropping `en` during ISSUE → the handshake still completes and earlier pending bits are still served.
- Assert `rst` for one cycle during ISSUE with `pending`=0110 → the next cycle shows `move_valid`=0, `pending`=0, `busy`=0, and a subsequent up pulse is granted with ptr=0.
